// File: rtl/adbg_top_pkg.sv
// Shared defaults and the status-chain word layout for the top-level debug-chain selector.
package adbg_top_pkg;

  localparam int DBG_TOP_ID_WIDTH = 5;
  localparam int DBG_TOP_DATA_LEN = 53;

  // Field order fixes the shift-out order: id LSB first, then sel_error, then inhibit_hit.
  typedef struct packed {
    logic                        inhibit_hit;
    logic                        sel_error;
    logic [DBG_TOP_ID_WIDTH-1:0] id;
  } adbg_top_status_t;

endpackage

// File: rtl/adbg_top_status_chain.sv
// Status register reported on TDO while the module ID is invalid: parallel load, LSB-first shift.
module adbg_top_status_chain
  import adbg_top_pkg::*;
#(
  parameter int STATUS_W = DBG_TOP_ID_WIDTH + 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [STATUS_W-1:0] load_val_i,
  output logic                status_bit_o
);

  logic [STATUS_W-1:0] status_q;
  logic [STATUS_W-1:0] status_d;

  // A load in the same cycle as a shift takes priority.
  always_comb begin
    status_d = status_q;
    if (load_i) begin
      status_d = load_val_i;
    end else if (shift_i) begin
      status_d = {1'b0, status_q[STATUS_W-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_bit_o = status_q[0];

endmodule

// File: rtl/adbg_top_mux.sv
// Top-level debug-chain selector: shared DR shift register, module-ID register,
// one-hot sub-module select, TDO return mux and invalid-ID status chain.
module adbg_top_mux
  import adbg_top_pkg::*;
#(
  parameter int NUM_MODULES = 4,
  parameter int ID_WIDTH    = DBG_TOP_ID_WIDTH,
  parameter int DATA_LEN    = DBG_TOP_DATA_LEN
) (
  input  logic                   tck_i,
  input  logic                   trst_i,
  input  logic                   tdi_i,
  output logic                   tdo_o,
  input  logic                   shift_dr_i,
  input  logic                   pause_dr_i,
  input  logic                   update_dr_i,
  input  logic                   capture_dr_i,
  input  logic                   debug_select_i,
  output logic [DATA_LEN-1:0]    data_register_o,
  output logic [NUM_MODULES-1:0] module_select_o,
  input  logic [NUM_MODULES-1:0] module_tdo_i,
  input  logic [NUM_MODULES-1:0] module_inhibit_i,
  output logic [ID_WIDTH-1:0]    module_id_o,
  output logic                   sel_error_o
);

  localparam int STATUS_W = ID_WIDTH + 2;
  localparam logic [ID_WIDTH:0] NUM_MODULES_W = (ID_WIDTH + 1)'(NUM_MODULES);

  logic [DATA_LEN-1:0] sr_q, sr_d;
  logic [ID_WIDTH-1:0] module_id_q, module_id_d;
  logic                sel_error_q, sel_error_d;
  logic                inhibit_hit_q, inhibit_hit_d;

  logic                select_cmd;
  logic [ID_WIDTH-1:0] id_in;
  logic                shift_en;
  logic                update_en;
  logic                status_load;
  logic                status_shift;
  logic                status_bit;

  // Pause-DR needs no term anywhere: every register already holds unless shifted/updated/captured.
  logic unused_pause;
  assign unused_pause = pause_dr_i;

  assign select_cmd   = sr_q[DATA_LEN-1];
  assign id_in        = sr_q[DATA_LEN-2 -: ID_WIDTH];
  assign shift_en     = debug_select_i && shift_dr_i;
  assign update_en    = debug_select_i && update_dr_i && select_cmd;
  assign status_load  = debug_select_i && capture_dr_i && sel_error_q;
  assign status_shift = debug_select_i && shift_dr_i && sel_error_q;

  // Update decodes sr_q, so a shift in the same cycle does not disturb the new module ID.
  always_comb begin
    sr_d          = sr_q;
    module_id_d   = module_id_q;
    sel_error_d   = sel_error_q;
    inhibit_hit_d = inhibit_hit_q;
    if (shift_en) begin
      sr_d = {tdi_i, sr_q[DATA_LEN-1:1]};
    end
    if (status_load) begin
      inhibit_hit_d = 1'b0;
    end
    // A blocked change set in the capture cycle is kept so it is not lost.
    if (update_en) begin
      if (|module_inhibit_i) begin
        inhibit_hit_d = 1'b1;
      end else begin
        module_id_d = id_in;
        sel_error_d = ({1'b0, id_in} >= NUM_MODULES_W);
      end
    end
  end

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      sr_q          <= '0;
      module_id_q   <= '0;
      sel_error_q   <= 1'b0;
      inhibit_hit_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      module_id_q   <= module_id_d;
      sel_error_q   <= sel_error_d;
      inhibit_hit_q <= inhibit_hit_d;
    end
  end

  adbg_top_status_chain #(
    .STATUS_W (STATUS_W)
  ) u_status_chain (
    .clk_i        (tck_i),
    .rst_i        (trst_i),
    .load_i       (status_load),
    .shift_i      (status_shift),
    .load_val_i   ({inhibit_hit_q, sel_error_q, module_id_q}),
    .status_bit_o (status_bit)
  );

  always_comb begin
    module_select_o = '0;
    for (int k = 0; k < NUM_MODULES; k++) begin
      module_select_o[k] = !sel_error_q && (module_id_q == ID_WIDTH'(k));
    end
  end

  // The return mux compares against each index so module_id_q never indexes past NUM_MODULES.
  always_comb begin
    tdo_o = 1'b0;
    if (debug_select_i) begin
      if (sel_error_q) begin
        tdo_o = status_bit;
      end else begin
        for (int k = 0; k < NUM_MODULES; k++) begin
          if (module_id_q == ID_WIDTH'(k)) begin
            tdo_o = module_tdo_i[k];
          end
        end
      end
    end
  end

  assign data_register_o = sr_q;
  assign module_id_o     = module_id_q;
  assign sel_error_o     = sel_error_q;

endmodule

// File: tb/tb_adbg_top_mux.sv
// Directed bench for adbg_top_mux: expected values are queued as each step is driven
// and popped when the matching DUT output is sampled.
module tb_adbg_top_mux;
  import adbg_top_pkg::*;

  localparam int NM = 4;
  localparam int IW = DBG_TOP_ID_WIDTH;
  localparam int DL = DBG_TOP_DATA_LEN;
  localparam int SW = IW + 2;

  logic          tck = 1'b0;
  logic          trst;
  logic          tdi;
  logic          tdo;
  logic          shift_dr;
  logic          pause_dr;
  logic          update_dr;
  logic          capture_dr;
  logic          debug_select;
  logic [DL-1:0] data_register;
  logic [NM-1:0] module_select;
  logic [NM-1:0] module_tdo;
  logic [NM-1:0] module_inhibit;
  logic [IW-1:0] module_id;
  logic          sel_error;

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  adbg_top_mux #(
    .NUM_MODULES (NM),
    .ID_WIDTH    (IW),
    .DATA_LEN    (DL)
  ) dut (
    .tck_i            (tck),
    .trst_i           (trst),
    .tdi_i            (tdi),
    .tdo_o            (tdo),
    .shift_dr_i       (shift_dr),
    .pause_dr_i       (pause_dr),
    .update_dr_i      (update_dr),
    .capture_dr_i     (capture_dr),
    .debug_select_i   (debug_select),
    .data_register_o  (data_register),
    .module_select_o  (module_select),
    .module_tdo_i     (module_tdo),
    .module_inhibit_i (module_inhibit),
    .module_id_o      (module_id),
    .sel_error_o      (sel_error)
  );

  // Clock and reset timing: inputs change 1 time unit after the rising edge.
  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_out(input string tag, input logic [63:0] obs);
    logic [63:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: got %0h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  function automatic logic [DL-1:0] make_word(input logic sel, input logic [IW-1:0] id);
    logic [DL-1:0] w;
    w = DL'({$urandom(), $urandom()});
    w[DL-1] = sel;
    w[DL-2 -: IW] = id;
    return w;
  endfunction

  // Driver tasks
  task automatic shift_word(input logic [DL-1:0] w);
    debug_select = 1'b1;
    shift_dr = 1'b1;
    for (int i = 0; i < DL; i++) begin
      tdi = w[i];
      tick();
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic update();
    debug_select = 1'b1;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic select_id(input logic sel, input logic [IW-1:0] id);
    shift_word(make_word(sel, id));
    update();
  endtask

  task automatic read_status(input adbg_top_status_t st, input string tag);
    debug_select = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b0;
    #1;
    for (int i = 0; i < SW; i++) begin
      expect_val(64'(st[i]));
      check_out(tag, 64'(tdo));
      tick();
    end
    shift_dr = 1'b0;
  endtask

  initial begin
    logic [DL-1:0] w;
    adbg_top_status_t st;

    trst = 1'b1;
    tdi = 1'b0;
    shift_dr = 1'b0;
    pause_dr = 1'b0;
    update_dr = 1'b0;
    capture_dr = 1'b0;
    debug_select = 1'b0;
    module_tdo = '0;
    module_inhibit = '0;
    repeat (2) tick();
    trst = 1'b0;
    #1;

    // Reset state
    expect_val(64'h1); check_out("rst_select", 64'(module_select));
    expect_val(64'h0); check_out("rst_id", 64'(module_id));
    expect_val(64'h0); check_out("rst_sel_error", 64'(sel_error));
    expect_val(64'h0); check_out("rst_dr", 64'(data_register));
    expect_val(64'h0); check_out("rst_tdo", 64'(tdo));

    // Select module 2; select appears the cycle after update
    w = make_word(1'b1, 5'd2);
    shift_word(w);
    expect_val(64'(w)); check_out("t1_dr", 64'(data_register));
    expect_val(64'h1); check_out("t1_select_pre", 64'(module_select));
    update();
    expect_val(64'b0100); check_out("t1_select", 64'(module_select));
    expect_val(64'd2); check_out("t1_id", 64'(module_id));
    module_tdo = 4'b0100;
    #1;
    expect_val(64'h1); check_out("t1_tdo_hi", 64'(tdo));
    module_tdo = 4'b1011;
    #1;
    expect_val(64'h0); check_out("t1_tdo_lo", 64'(tdo));

    // Invalid ID 7: selects drop, status chain drives TDO
    select_id(1'b1, 5'd7);
    expect_val(64'h0); check_out("t2_select", 64'(module_select));
    expect_val(64'h1); check_out("t2_sel_error", 64'(sel_error));
    expect_val(64'd7); check_out("t2_id", 64'(module_id));
    st = '{inhibit_hit: 1'b0, sel_error: 1'b1, id: 5'd7};
    read_status(st, "t2_status");
    #1;
    expect_val(64'h0); check_out("t2_status_drained", 64'(tdo));

    // Inhibit blocks the change; the hit is reported once on the next capture
    select_id(1'b1, 5'd2);
    expect_val(64'd2); check_out("t3_id_base", 64'(module_id));
    module_inhibit = 4'b0010;
    select_id(1'b1, 5'd3);
    expect_val(64'd2); check_out("t3_id_held", 64'(module_id));
    expect_val(64'b0100); check_out("t3_select_held", 64'(module_select));
    module_inhibit = '0;
    select_id(1'b1, 5'd5);
    expect_val(64'h1); check_out("t3_sel_error", 64'(sel_error));
    st = '{inhibit_hit: 1'b1, sel_error: 1'b1, id: 5'd5};
    read_status(st, "t3_status_hit");
    st = '{inhibit_hit: 1'b0, sel_error: 1'b1, id: 5'd5};
    read_status(st, "t3_status_clear");

    // Update with select_cmd = 0 leaves the module ID alone
    w = make_word(1'b0, 5'd1);
    shift_word(w);
    update();
    expect_val(64'd5); check_out("t4_id", 64'(module_id));
    expect_val(64'(w)); check_out("t4_dr", 64'(data_register));
    expect_val(64'h1); check_out("t4_sel_error", 64'(sel_error));

    // ID boundary: NUM_MODULES-1 valid, NUM_MODULES invalid
    select_id(1'b1, 5'(NM - 1));
    expect_val(64'b1000); check_out("b_last_select", 64'(module_select));
    expect_val(64'h0); check_out("b_last_sel_error", 64'(sel_error));
    select_id(1'b1, 5'(NM));
    expect_val(64'h1); check_out("b_over_sel_error", 64'(sel_error));
    expect_val(64'h0); check_out("b_over_select", 64'(module_select));

    // Shift and update together: update decodes the pre-shift register
    w = make_word(1'b1, 5'd1);
    shift_word(w);
    shift_dr = 1'b1;
    update_dr = 1'b1;
    tdi = 1'b0;
    tick();
    shift_dr = 1'b0;
    update_dr = 1'b0;
    expect_val(64'd1); check_out("b_shupd_id", 64'(module_id));
    expect_val(64'b0010); check_out("b_shupd_select", 64'(module_select));
    expect_val(64'({1'b0, w[DL-1:1]})); check_out("b_shupd_dr", 64'(data_register));

    // Capture and shift together: capture wins
    select_id(1'b1, 5'd7);
    capture_dr = 1'b1;
    shift_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b0;
    expect_val(64'h1); check_out("b_capshift_tdo", 64'(tdo));

    // Reset in the middle of a shift discards the partial DR
    w = make_word(1'b1, 5'd3);
    debug_select = 1'b1;
    shift_dr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tdi = w[i];
      tick();
    end
    trst = 1'b1;
    tick();
    trst = 1'b0;
    shift_dr = 1'b0;
    tdi = 1'b0;
    expect_val(64'h0); check_out("t5_dr", 64'(data_register));
    expect_val(64'b0001); check_out("t5_select", 64'(module_select));
    expect_val(64'h0); check_out("t5_sel_error", 64'(sel_error));
    expect_val(64'h0); check_out("t5_id", 64'(module_id));

    // Debug instruction inactive: TAP activity changes nothing and TDO stays low
    module_tdo = 4'b1111;
    debug_select = 1'b0;
    for (int i = 0; i < 8; i++) begin
      shift_dr = i[0];
      update_dr = ~i[0];
      pause_dr = i[1];
      capture_dr = i[2];
      tdi = 1'b1;
      tick();
      expect_val(64'h0); check_out("t6_tdo", 64'(tdo));
    end
    shift_dr = 1'b0;
    update_dr = 1'b0;
    pause_dr = 1'b0;
    capture_dr = 1'b0;
    expect_val(64'h0); check_out("t6_dr", 64'(data_register));
    expect_val(64'h0); check_out("t6_id", 64'(module_id));
    expect_val(64'b0001); check_out("t6_select", 64'(module_select));

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
